multi_debounce_sync: RTL
========================

Name: multi_debounce_sync

Overview:
- Multi-channel successor to the single-bit synchronizer. Each of WIDTH asynchronous, noisy inputs gets its own NUM_STAGES-deep synchronizer and a per-channel stability counter.
- Outputs per channel: a debounced level plus single-cycle rise and fall pulses.
- Sits between board-level buttons/switches and control FSMs in the clk domain.

Parameters:
- WIDTH, 4, number of independent input channels (>=1).
- NUM_STAGES, 2, synchronizer flops per channel (>=2).
- CNT_W, 16, width of the stability counters and of the limit port.

Ports:
- clk  input  1  single system clock; all flops clock on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- noisy_in  input  WIDTH  raw asynchronous inputs; bit i is channel i.
- limit  input  CNT_W  stability threshold in clk cycles; quasi-static; 0 is treated as 1.
- db_out  output  WIDTH  debounced level per channel (registered).
- rise  output  WIDTH  one-cycle pulse when db_out[i] goes 0->1 (registered).
- fall  output  WIDTH  one-cycle pulse when db_out[i] goes 1->0 (registered).
- any_change  output  1  OR-reduction of (rise | fall); combinational from registered pulses.

Behaviour:
- Reset (rst=1, asynchronous): all sync flops, counters, db_out, rise and fall go to 0. any_change is therefore 0. Reset mid-count discards the count; no pulse is generated by reset or by its release.
- Sync chain, per channel:
  - stage0 <= noisy_in[i]; stage k <= stage k-1.
  - s[i] = last stage.
  - Latency from noisy_in to s is NUM_STAGES cycles.
- Effective limit: L = (limit==0) ? 1 : limit.
- Per channel, at each clk edge:
  - s==db_out: cnt <= 0; rise, fall <= 0.
  - s!=db_out and cnt+1 >= L: db_out <= s; cnt <= 0; rise <= s; fall <= ~s.
  - s!=db_out otherwise: cnt <= cnt+1; rise, fall <= 0.
- db_out flips on the L-th consecutive edge at which s differs from db_out.
- Total latency from a clean step on noisy_in to db_out/rise/fall is NUM_STAGES+L cycles.
- Glitches: any mismatch run shorter than L edges leaves db_out unchanged and produces no pulse. The first matching sample clears cnt, so the next run starts from 0.
- Pulses: rise and fall are exactly 1 cycle wide, never both set on one channel, and asserted in the same cycle db_out changes.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle, and any_change is 1 for that cycle.
- Counter overflow: cnt never exceeds L-1. It is width CNT_W and cannot wrap.
- limit changed mid-count: the new L applies from the next edge. If cnt+1 >= new L, db_out flips at that edge.
- Back-to-back: after a flip, cnt=0. A reverse transition needs another full L edges.
- No combinational path from noisy_in or limit to db_out, rise or fall.

Test Plan:
- Reset/idle: WIDTH=4, NUM_STAGES=2, limit=4, hold rst=1 then release with noisy_in=0 -> db_out=0, rise=fall=0, any_change=0 indefinitely.
- Clean step: noisy_in[0] 0->1 at edge T and held -> db_out[0]=1 from edge T+6. rise[0]=1 only for that cycle; other channels stay 0.
- Glitch rejection: noisy_in[1] high for 3 cycles, low for 1, high for 3, then low -> db_out[1] stays 0; no rise or fall pulses.
- Simultaneous multi-channel: noisy_in 4'b0000->4'b1010 held, then 4'b0000 after 10 cycles -> rise=4'b1010 for one cycle, later fall=4'b1010 for one cycle. any_change pulses twice.
- limit=0 and limit=1: step on channel 2 -> db_out[2] changes NUM_STAGES+1=3 cycles after the input step in both cases.
- Reset mid-count: channel 3 high for 5 cycles with limit=8, then assert rst for 1 cycle, release with input still high -> no pulse before reset. rise[3] fires 2+8=10 cycles after rst deasserts.

Source files
------------

// File: rtl/multi_debounce_sync.sv
`timescale 1ns/1ps
// multi_debounce_sync: per-channel synchronizer chain followed by a
// stability counter; emits a debounced level plus one-cycle rise/fall pulses.
module multi_debounce_sync #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] noisy_in,
  input  logic [CNT_W-1:0] limit,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] r_sync [NUM_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_db;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  logic [CNT_W-1:0] w_lim;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_hit;

  // Effective threshold: zero behaves as one.
  always_comb begin
    w_lim = (limit == '0) ? CNT_W'(1) : limit;
  end

  assign w_s = r_sync[NUM_STAGES-1];

  // Threshold reached on this edge; compared one bit wider so cnt+1 cannot wrap.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_hit[i] = (({1'b0, r_cnt[i]} + (CNT_W+1)'(1)) >= {1'b0, w_lim});
    end
  end

  // Synchronizer chain: stage 0 captures the raw inputs, each stage shifts on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= noisy_in;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Per-channel stability counter, debounced level and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_db   <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (w_s[i] == r_db[i]) begin
          r_cnt[i]  <= '0;
          r_rise[i] <= 1'b0;
          r_fall[i] <= 1'b0;
        end else if (w_hit[i]) begin
          r_db[i]   <= w_s[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= w_s[i];
          r_fall[i] <= ~w_s[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_rise[i] <= 1'b0;
          r_fall[i] <= 1'b0;
        end
      end
    end
  end

  assign db_out     = r_db;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign any_change = |(r_rise | r_fall);

endmodule
